// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if
//   Groups the stopwatch button inputs and the display/status outputs.
//   No valid/ready handshake: buttons are free-running debounced levels
//   (asynchronous to clk, synchronized inside the core) and every output
//   is a continuously valid level that the consumer may sample any cycle.
//
//   button0    : start/stop level
//   button1    : lap/clear level
//   digit_data : BCD {sec_tens, sec_units, hund_tens, hund_units}
//   running    : high in RUNNING or LAP
//   lap_active : high in LAP (display frozen)
//   overflow   : sticky, set when the count wraps 99.99 -> 00.00
//   state_dbg  : current FSM state encoding, for checkers/debug
interface stopwatch_core_if;
  logic        button0;
  logic        button1;
  logic [15:0] digit_data;
  logic        running;
  logic        lap_active;
  logic        overflow;
  logic [1:0]  state_dbg;

  modport master (
    output button0, button1,
    input  digit_data, running, lap_active, overflow, state_dbg
  );

  modport slave (
    input  button0, button1,
    output digit_data, running, lap_active, overflow, state_dbg
  );
endinterface

// File: rtl/stopwatch_core.sv
// stopwatch_core
//   Stopwatch engine counting 00.00 - 99.99 s in BCD at 10 ms resolution
//   for a seven-segment display driver. A four-state FSM (IDLE, RUNNING,
//   LAP, PAUSED) sequences start/stop, lap freeze and clear.
//
//   Optional feature macro: STOPWATCH_LAP_EN
//     defined   : LAP state, lap register and lap_active are built.
//     undefined : press1 in RUNNING is ignored, lap_active is 0 and the
//                 display always shows the live count.
//
//   Ports:
//     clk   : system clock (100 MHz)
//     reset : asynchronous, active-low reset
//     sw    : stopwatch_core_if.slave (buttons in, display/status out)
//
//   Parameter:
//     TICK_DIV : clk cycles per 10 ms count step (>= 2)
module stopwatch_core #(
  parameter int TICK_DIV = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_core_if.slave  sw
);

  localparam int             PW  = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  TOP = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_LAP     = 2'd2,
    S_PAUSED  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    b0_sync;
  logic [1:0]    b1_sync;
  logic          b0_prev;
  logic          b1_prev;
  logic          press0;
  logic          press1;
  logic          counting;
  logic          tick;
  logic          clear_all;
  logic [PW-1:0] presc;
  logic [15:0]   count;
  logic [15:0]   disp_q;
  logic          ovf_q;
`ifdef STOPWATCH_LAP_EN
  logic          capture_lap;
  logic [15:0]   lap_reg;
`endif

  // Ripple-carry BCD increment; each nibble wraps 9 -> 0 and carries on.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Two-flop synchronizers plus previous-value registers for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b0_sync <= 2'b00;
      b1_sync <= 2'b00;
      b0_prev <= 1'b0;
      b1_prev <= 1'b0;
    end else begin
      b0_sync <= {b0_sync[0], sw.button0};
      b1_sync <= {b1_sync[0], sw.button1};
      b0_prev <= b0_sync[1];
      b1_prev <= b1_sync[1];
    end
  end

  assign press0 = b0_sync[1] & ~b0_prev;
  assign press1 = b1_sync[1] & ~b1_prev;

  assign counting = (state == S_RUNNING) || (state == S_LAP);
  assign tick     = counting && (presc == TOP);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; press0 is checked first so it wins over press1.
  always_comb begin
    state_next  = state;
    clear_all   = 1'b0;
`ifdef STOPWATCH_LAP_EN
    capture_lap = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (press0) state_next = S_RUNNING;
      end
      S_RUNNING: begin
        if (press0) begin
          state_next = S_PAUSED;
        end
`ifdef STOPWATCH_LAP_EN
        else if (press1) begin
          state_next  = S_LAP;
          capture_lap = 1'b1;
        end
`endif
      end
      S_LAP: begin
`ifdef STOPWATCH_LAP_EN
        if (press0)      state_next = S_PAUSED;
        else if (press1) state_next = S_RUNNING;
`else
        state_next = S_IDLE;
`endif
      end
      S_PAUSED: begin
        if (press0) begin
          state_next = S_RUNNING;
        end else if (press1) begin
          state_next = S_IDLE;
          clear_all  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Prescaler holds while paused so a partial interval survives a pause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (clear_all) begin
      presc <= '0;
    end else if (counting) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // Live BCD count and sticky overflow. A tick on the same edge as a
  // press0 is still counted because counting uses the current state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 16'h0000;
      ovf_q <= 1'b0;
    end else if (clear_all) begin
      count <= 16'h0000;
      ovf_q <= 1'b0;
    end else if (tick) begin
      count <= bcd_inc(count);
      if (count == 16'h9999) ovf_q <= 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_reg <= 16'h0000;
    end else if (capture_lap) begin
      lap_reg <= count;
    end
  end
`endif

  // Registered display: frozen lap value in LAP, live count otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q <= 16'h0000;
    end else begin
`ifdef STOPWATCH_LAP_EN
      disp_q <= (state == S_LAP) ? lap_reg : count;
`else
      disp_q <= count;
`endif
    end
  end

  assign sw.digit_data = disp_q;
  assign sw.running    = counting;
  assign sw.overflow   = ovf_q;
  assign sw.state_dbg  = state;
`ifdef STOPWATCH_LAP_EN
  assign sw.lap_active = (state == S_LAP);
`else
  assign sw.lap_active = 1'b0;
`endif

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Stopwatch engine that drives the seven-segment display's 16-bit `digit_data` input. It consumes the two debounced button levels and counts elapsed time in BCD. The range is 00.00–99.99 seconds at 10 ms resolution. Start/stop, lap-freeze and clear are sequenced by a four-state FSM, and the block runs on the 100 MHz system clock.

## Interface
- `TICK_DIV`, default 1000000: clk cycles per 10 ms count step. Legal range is ≥ 2.
- `clk`, input, 1: system clock, 100 MHz.
- `reset`, input, 1: asynchronous, active-low reset.
- `button0`, input, 1: debounced start/stop level, asynchronous to `clk`.
- `button1`, input, 1: debounced lap/clear level, asynchronous to `clk`.
- `digit_data`, output, 16: BCD digits {sec_tens, sec_units, hund_tens, hund_units}, MS nibble leftmost.
- `running`, output, 1: high in RUNNING or LAP.
- `lap_active`, output, 1: high in LAP, meaning the display is frozen.
- `overflow`, output, 1: sticky flag, set when the count wraps 99.99→00.00.

## Operation
- Each button passes through a 2-flop synchronizer followed by a previous-value register.
  - A press is a one-cycle pulse when the synchronized level is 1 and the previous value is 0.
  - Held or released levels generate nothing.
- Prescaler: a `$clog2(TICK_DIV)`-bit counter.
  - Counts only in RUNNING and LAP.
  - At TICK_DIV-1 it wraps to 0 and asserts `tick` for one cycle.
  - Holds its value in PAUSED, so a partial interval is preserved across pause.
- BCD counter: four nibbles, each 0–9.
  - On `tick`, hund_units increments. Each nibble going 9→0 carries into the next nibble.
  - 99.99 + tick → 00.00, `overflow`←1, and the stopwatch keeps running.
  - No nibble ever holds A–F.
- FSM states: IDLE, RUNNING, LAP, PAUSED.
  - IDLE: press0 → RUNNING. press1 is ignored.
  - RUNNING: press0 → PAUSED. press1 → LAP, and the current count is captured into the lap register.
  - LAP: the count keeps advancing. press1 → RUNNING, and the live count is displayed again. press0 → PAUSED, and the live count is displayed.
  - PAUSED: press0 → RUNNING. press1 → IDLE, and the count, prescaler and `overflow` are cleared.
- Simultaneous press0 and press1 in the same cycle: press0 wins and press1 is discarded.
- `tick` and press0 on the same edge when leaving RUNNING or LAP: that tick is counted, then the FSM enters PAUSED.
- `digit_data` is registered. It takes the lap register in LAP and the live count otherwise.
- Reset asserted (low): all state clears immediately and asynchronously, from any state, including mid-count.

## Timing
- Reset values:
  - `digit_data` = 16'h0000, `running` = 0, `lap_active` = 0, `overflow` = 0.
  - FSM = IDLE, prescaler = 0, lap register = 0, synchronizers = 0.
- Reset release: the first active edge is the first `clk` edge with `reset` high.
- Press latency: let edge 0 be the first edge sampling a button high.
  - The FSM, `running` and `lap_active` change at edge 2.
  - `digit_data` reflects the press (lap freeze or clear) at edge 3.
- Ticks:
  - The first `tick` after IDLE→RUNNING occurs TICK_DIV cycles after the transition edge.
  - The count nibbles update on the `tick` edge, and `digit_data` updates one edge later.
- `overflow` sets on the same edge the count wraps to 0000.

## Configuration
- `STOPWATCH_LAP_EN` defined: LAP state, lap register and `lap_active` behave as described above.
- `STOPWATCH_LAP_EN` undefined:
  - The LAP state and lap register are not built.
  - press1 in RUNNING is ignored. press1 in PAUSED still clears.
  - `lap_active` is tied to 0, and `digit_data` always shows the live count.

## Test plan
All scenarios use TICK_DIV = 4 and `STOPWATCH_LAP_EN` defined unless noted.
- Reset then run: release reset, then pulse button0 → `running`=1 at edge 2; `digit_data`=16'h0001 one edge after the 4th post-transition cycle; 100 ticks → 16'h0100.
- Pause and resume: stop 2 cycles into an interval, wait 50 cycles, then restart → `digit_data` frozen during pause; next increment arrives 2 cycles after restart.
- Lap: while running at 16'h0230, press button1 → `digit_data` holds 16'h0230 while the internal count advances; press button1 again → live value shown, greater than 16'h0230.
- Wrap: preload by running to 16'h9999, then one tick → `digit_data`=16'h0000, `overflow`=1, `running`=1. Pause, then press button1 → `overflow`=0, state IDLE.
- Priority and glitches: button0 and button1 rise on the same cycle in RUNNING → PAUSED, not LAP. A button held high for 1000 cycles → exactly one transition.
- Async reset mid-count: drive `reset` low at 16'h0457 between clock edges → all outputs 0 before the next edge. Repeat with `STOPWATCH_LAP_EN` undefined → button1 in RUNNING leaves the state unchanged and `lap_active` stays 0.
